// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential signed divider: controller state
// encoding and the default datapath width.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring division iteration on unsigned magnitudes: shift {rem, quo}
// left, then subtract the divisor from the remainder when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, dvsr_i};
    // rem_i < dvsr_i always holds, so shifted < 2*dvsr_i and the top bit of
    // diff is set exactly when the subtraction borrows.
    fits    = ~diff[WIDTH];
    rem_o   = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/seq_divider.sv
// Multicycle signed divider (MIPS DIV): lo = quotient, hi = remainder.
// Restoring shift-subtract on magnitudes, then sign correction in FIX.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             div_end,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sgn_quo_q, sgn_quo_d;
  logic             sgn_rem_q, sgn_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_end_q, div_end_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    cnt_d     = cnt_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    div_end_d = 1'b0;
    dbz_d     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (div_start) begin
          if (divisor == '0) begin
            state_d   = DONE;
            div_end_d = 1'b1;
            dbz_d     = 1'b1;
          end else begin
            // Magnitudes are unsigned, so the most negative value maps to itself.
            quo_d     = dividend[WIDTH-1] ? -dividend : dividend;
            dvsr_d    = divisor[WIDTH-1] ? -divisor : divisor;
            rem_d     = '0;
            sgn_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sgn_rem_d = dividend[WIDTH-1];
            cnt_d     = CNT_W'(WIDTH);
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        lo_d      = sgn_quo_q ? -quo_q : quo_q;
        hi_d      = sgn_rem_q ? -rem_q : rem_q;
        div_end_d = 1'b1;
        state_d   = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == FIX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      div_end_q <= 1'b0;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      cnt_q     <= cnt_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      div_end_q <= div_end_d;
      dbz_q     <= dbz_d;
      busy_q    <= busy_d;
    end
  end

  assign div_end     = div_end_q;
  assign div_by_zero = dbz_q;
  assign busy        = busy_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, multi-cycle
// corner sequences, and random operands against a 64-bit arithmetic model.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         div_start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         div_end;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;
  logic         busy;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] prev_lo;
  logic [W-1:0] prev_hi;

  seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .div_start   (div_start),
    .dividend    (dividend),
    .divisor     (divisor),
    .div_end     (div_end),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_lo;
    logic [W-1:0] exp_hi;
    logic         exp_dbz;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: truncating signed division done in 64-bit arithmetic.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb, lq, lr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lq = sa / sb;
    lr = sa % sb;
    q  = lq[W-1:0];
    r  = lr[W-1:0];
  endfunction

  // Presents operands for one edge; returns 1ns after the sampling edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    div_start = 1'b1;
    @(posedge clk);
    #1;
    div_start = 1'b0;
  endtask

  task automatic wait_end(inout int lat);
    while (!div_end && lat < 80) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] elo, input logic [W-1:0] ehi, input logic edbz);
    int lat;
    lat = 0;
    launch(a, b);
    if (b != '0) check({tag, ".busy"}, 64'(busy), 64'(1'b1));
    wait_end(lat);
    check({tag, ".latency"}, 64'(lat), (b == '0) ? 64'd0 : 64'd33);
    check({tag, ".lo"}, 64'(lo), 64'(elo));
    check({tag, ".hi"}, 64'(hi), 64'(ehi));
    check({tag, ".dbz"}, 64'(div_by_zero), 64'(edbz));
    $display("op %s: %h / %h -> lo=%h hi=%h dbz=%0b lat=%0d", tag, a, b, lo, hi, div_by_zero, lat);
    @(posedge clk);
    #1;
    check({tag, ".end_pulse"}, 64'({div_end, div_by_zero}), 64'd0);
    prev_lo = elo;
    prev_hi = ehi;
  endtask

  initial begin
    int lat;
    int stray;
    logic [W-1:0] a, b, q, r;

    vecs[0] = '{32'd7,        32'd2,        32'd3,        32'd1,        1'b0};
    vecs[1] = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vecs[2] = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
    vecs[3] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
    vecs[4] = '{32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0};
    vecs[5] = '{32'd100,      32'd7,        32'd14,       32'd2,        1'b0};
    vecs[6] = '{32'h12345678, 32'd0,        32'd14,       32'd2,        1'b1};
    vecs[7] = '{32'd0,        32'd5,        32'd0,        32'd0,        1'b0};
    vecs[8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};

    rst       = 1'b0;
    div_start = 1'b0;
    dividend  = '0;
    divisor   = '0;
    prev_lo   = '0;
    prev_hi   = '0;

    #12;
    check("reset.lo", 64'(lo), 64'd0);
    check("reset.hi", 64'(hi), 64'd0);
    check("reset.flags", 64'({div_end, div_by_zero, busy}), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_lo, vecs[i].exp_hi, vecs[i].exp_dbz);
    end

    // Second request while running must be ignored, including operand changes.
    lat = 0;
    launch(32'd100, 32'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
      lat++;
    end
    @(negedge clk);
    dividend  = 32'd9;
    divisor   = 32'd3;
    div_start = 1'b1;
    @(posedge clk);
    #1;
    lat++;
    div_start = 1'b0;
    divisor   = 32'd0;
    wait_end(lat);
    check("ignore.latency", 64'(lat), 64'd33);
    check("ignore.lo", 64'(lo), 64'd14);
    check("ignore.hi", 64'(hi), 64'd2);
    $display("op ignore: 100 / 7 with restart attempt -> lo=%h hi=%h lat=%0d", lo, hi, lat);

    // New request presented during the DONE cycle is accepted immediately.
    dividend  = 32'd9;
    divisor   = 32'd3;
    div_start = 1'b1;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    lat = 1;
    check("b2b.end_low", 64'(div_end), 64'd0);
    check("b2b.busy", 64'(busy), 64'd1);
    wait_end(lat);
    check("b2b.latency", 64'(lat), 64'd34);
    check("b2b.lo", 64'(lo), 64'd3);
    check("b2b.hi", 64'(hi), 64'd0);
    $display("op b2b: 9 / 3 from DONE -> lo=%h hi=%h lat=%0d", lo, hi, lat);
    @(posedge clk);
    #1;
    check("b2b.end_pulse", 64'(div_end), 64'd0);

    // Asynchronous reset in the middle of an operation.
    launch(32'd1000, 32'd3);
    repeat (14) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid.busy", 64'(busy), 64'd0);
    check("rst_mid.hilo", 64'({hi, lo}), 64'd0);
    check("rst_mid.end", 64'(div_end), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    stray = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (div_end || busy) stray++;
    end
    check("rst_mid.no_end", 64'(stray), 64'd0);
    $display("op rst_mid: 1000 / 3 aborted, stray=%0d", stray);
    prev_lo = '0;
    prev_hi = '0;

    for (int n = 0; n < 250; n++) begin
      a = $urandom;
      if ($urandom_range(0, 9) == 0) a = 32'h80000000;
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 20));
        2: b = -32'($urandom_range(1, 20));
        3: b = $urandom & 32'h0000FFFF;
        default: b = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'hFFFFFFFF;
      endcase
      if (b == '0) begin
        do_op("rand", a, b, prev_lo, prev_hi, 1'b1);
      end else begin
        ref_div(a, b, q, r);
        do_op("rand", a, b, q, r, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
